// File: rtl/pvd_pkg.sv
// Shared types and helpers for the pin vector driver.
// Optional failure counter is enabled with PVD_FAILCNT_EN.
package pvd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    REPORT
  } pvd_state_e;

  localparam int SETTLE_W = 8;
  localparam int SAT_W    = 32;

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input int unsigned      w
  );
    logic [SAT_W-1:0] top;
    if (w >= SAT_W) top = '1;
    else top = (SAT_W'(1) << w) - SAT_W'(1);
    return (v >= top) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/pin_vector_stats.sv
// Completed-vector and failure counters with clear priority.
// fail_cnt and the pass input exist only with PVD_FAILCNT_EN.
module pin_vector_stats
  import pvd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
`ifdef PVD_FAILCNT_EN
  input  logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
`endif
  input  logic             clr,
  output logic [CNT_W-1:0] vec_cnt
);

  if (CNT_W < 1 || CNT_W > SAT_W) begin : g_bad_w
    $error("pin_vector_stats: CNT_W out of range");
  end

  logic [CNT_W-1:0] vec_q;

  assign vec_cnt = vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else if (clr) begin
      vec_q <= '0;
    end else if (done) begin
      vec_q <= CNT_W'(sat_inc(SAT_W'(vec_q), CNT_W));
    end
  end

`ifdef PVD_FAILCNT_EN
  logic [CNT_W-1:0] fail_q;

  assign fail_cnt = fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= '0;
    end else if (clr) begin
      fail_q <= '0;
    end else if (done && !pass) begin
      fail_q <= CNT_W'(sat_inc(SAT_W'(fail_q), CNT_W));
    end
  end
`endif

endmodule

// File: rtl/pin_vector_driver.sv
// Drives stimulus onto chip pins, waits a settle window, checks outputs.
// Define PVD_FAILCNT_EN to add the fail_cnt port.
module pin_vector_driver
  import pvd_pkg::*;
#(
  parameter int N_IN          = 8,
  parameter int N_OUT         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic [N_OUT-1:0] in_exp,
  input  logic [N_OUT-1:0] in_mask,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_OUT-1:0] res_obs,
  output logic             res_pass,
  input  logic             clr_stats,
`ifdef PVD_FAILCNT_EN
  output logic [CNT_W-1:0] fail_cnt,
`endif
  output logic [CNT_W-1:0] vec_cnt
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("pin_vector_driver: SETTLE_CYCLES must be 1..255");
  end

  localparam logic [SETTLE_W-1:0] LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  pvd_state_e         state;
  logic [SETTLE_W-1:0] cnt;
  logic [N_OUT-1:0]    exp_q;
  logic [N_OUT-1:0]    mask_q;
  logic                done;

  assign done = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      dut_in    <= '0;
      res_obs   <= '0;
      res_pass  <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dut_in   <= in_vec;
            exp_q    <= in_exp;
            mask_q   <= in_mask;
            cnt      <= LOAD;
            in_ready <= 1'b0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            res_obs   <= dut_out;
            res_pass  <= ~|((dut_out ^ exp_q) & mask_q);
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pin_vector_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk     (clk),
    .rst_n   (rst_n),
    .done    (done),
`ifdef PVD_FAILCNT_EN
    .pass    (res_pass),
    .fail_cnt(fail_cnt),
`endif
    .clr     (clr_stats),
    .vec_cnt (vec_cnt)
  );

endmodule

// File: tb/tb_pin_vector_driver.sv
// Directed bench for pin_vector_driver driving a quad 2-input AND model.
// Build with or without PVD_FAILCNT_EN.
module tb_pin_vector_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_vec, dut_in;
  logic [3:0]  in_exp, in_mask, dut_out, res_obs;
  logic        res_valid, res_ready, res_pass, clr_stats;
  logic [15:0] vec_cnt;
`ifdef PVD_FAILCNT_EN
  logic [15:0] fail_cnt;
`endif

  logic        in_valid1, in_ready1;
  logic [7:0]  in_vec1, dut_in1;
  logic [3:0]  in_exp1, in_mask1, res_obs1;
  logic [3:0]  dut_out1 = 4'h0;
  logic        res_valid1, res_pass1;
  logic [15:0] vec_cnt1;
`ifdef PVD_FAILCNT_EN
  logic [15:0] fail_cnt1;
`endif

  int total = 0;
  int bad = 0;
  int n;

  always #5 clk = ~clk;

  function automatic logic [3:0] and_q(input logic [7:0] v);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = v[2*i] & v[2*i+1];
    return y;
  endfunction

  assign dut_out = and_q(dut_in);

  // Slow chip: outputs follow the pins 3 ns after they change.
  always @(dut_in1) dut_out1 <= #3 and_q(dut_in1);

  pin_vector_driver #(
    .N_IN(8), .N_OUT(4), .SETTLE_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_exp(in_exp), .in_mask(in_mask),
    .dut_in(dut_in), .dut_out(dut_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_obs(res_obs), .res_pass(res_pass),
    .clr_stats(clr_stats),
`ifdef PVD_FAILCNT_EN
    .fail_cnt(fail_cnt),
`endif
    .vec_cnt(vec_cnt)
  );

  pin_vector_driver #(
    .N_IN(8), .N_OUT(4), .SETTLE_CYCLES(1), .CNT_W(16)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_vec(in_vec1), .in_exp(in_exp1), .in_mask(in_mask1),
    .dut_in(dut_in1), .dut_out(dut_out1),
    .res_valid(res_valid1), .res_ready(1'b1),
    .res_obs(res_obs1), .res_pass(res_pass1),
    .clr_stats(1'b0),
`ifdef PVD_FAILCNT_EN
    .fail_cnt(fail_cnt1),
`endif
    .vec_cnt(vec_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic [3:0] e, input logic [3:0] m);
    @(negedge clk);
    in_valid = 1'b1; in_vec = v; in_exp = e; in_mask = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n), 32'd2);
  endtask

  task automatic ack();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; in_exp = '0; in_mask = '0;
    res_ready = 1'b1; clr_stats = 1'b0;
    in_valid1 = 1'b0; in_vec1 = '0; in_exp1 = '0; in_mask1 = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", 32'({res_valid, res_pass, dut_in, res_obs}), 32'd0);
    chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // all ones through the AND gates
    send(8'hFF, 4'hF, 4'hF);
    chk("t1_dut_in", 32'(dut_in), 32'hFF);
    wait_res("t1_latency");
    chk("t1_obs", 32'(res_obs), 32'hF);
    chk("t1_pass", 32'(res_pass), 32'd1);
    ack();
    chk("t1_valid_drop", 32'(res_valid), 32'd0);
    chk("t1_vec_cnt", 32'(vec_cnt), 32'd1);
    chk("t1_dut_in_hold", 32'(dut_in), 32'hFF);

    // A=1, B=0 everywhere: all outputs low, mismatch
    send(8'h55, 4'hF, 4'hF);
    wait_res("t2_latency");
    chk("t2_obs", 32'(res_obs), 32'h0);
    chk("t2_pass", 32'(res_pass), 32'd0);
    ack();
    chk("t2_vec_cnt", 32'(vec_cnt), 32'd2);
`ifdef PVD_FAILCNT_EN
    chk("t2_fail_cnt", 32'(fail_cnt), 32'd1);
`endif
    send(8'h55, 4'hF, 4'h0);
    wait_res("t2m_latency");
    chk("t2m_pass", 32'(res_pass), 32'd1);
    ack();
    chk("t2m_vec_cnt", 32'(vec_cnt), 32'd3);
`ifdef PVD_FAILCNT_EN
    chk("t2m_fail_cnt", 32'(fail_cnt), 32'd1);
`endif

    // host stalls the result for 10 cycles
    res_ready = 1'b0;
    send(8'hAA, 4'h0, 4'hF);
    wait_res("t3_latency");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_vec = 8'h33;
      @(negedge clk);
      chk("t3_hold", 32'({res_valid, in_ready, dut_in, res_obs, res_pass}),
          32'({1'b1, 1'b0, 8'hAA, 4'h0, 1'b1}));
    end
    chk("t3_vec_cnt_stall", 32'(vec_cnt), 32'd3);
    in_valid = 1'b0;
    res_ready = 1'b1;
    ack();
    chk("t3_vec_cnt", 32'(vec_cnt), 32'd4);
    @(negedge clk);
    chk("t3_vec_cnt_once", 32'(vec_cnt), 32'd4);
    chk("t3_idle", 32'({in_ready, res_valid, dut_in}), 32'({1'b1, 1'b0, 8'hAA}));

    // saturation, then clear on the handshake edge
    force dut.u_stats.vec_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.u_stats.vec_q;
    chk("t4_preload", 32'(vec_cnt), 32'hFFFF);
    send(8'hFF, 4'hF, 4'hF);
    wait_res("t4_latency");
    ack();
    chk("t4_saturate", 32'(vec_cnt), 32'hFFFF);
    send(8'hFF, 4'hF, 4'hF);
    wait_res("t4c_latency");
    clr_stats = 1'b1;
    ack();
    clr_stats = 1'b0;
    chk("t4_clr", 32'(vec_cnt), 32'd0);
    chk("t4_clr_fsm", 32'({in_ready, res_valid}), 32'({1'b1, 1'b0}));
`ifdef PVD_FAILCNT_EN
    chk("t4_clr_fail", 32'(fail_cnt), 32'd0);
`endif

    // reset in the middle of SETTLE
    send(8'hFF, 4'hF, 4'hF);
    wait_res("t5a_latency");
    ack();
    chk("t5_pre_cnt", 32'(vec_cnt), 32'd1);
    send(8'h0F, 4'h3, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", 32'({dut_in, res_valid, in_ready}), 32'({8'h00, 1'b0, 1'b1}));
    chk("t5_rst_cnt", 32'(vec_cnt), 32'd0);
    @(negedge clk);
    chk("t5_no_result", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    send(8'h0F, 4'h3, 4'hF);
    wait_res("t5_latency");
    chk("t5_obs", 32'({res_obs, res_pass}), 32'({4'h3, 1'b1}));
    ack();
    chk("t5_vec_cnt", 32'(vec_cnt), 32'd1);

    // SETTLE_CYCLES=1 with a chip that reacts within the cycle
    @(negedge clk);
    in_valid1 = 1'b1; in_vec1 = 8'hF0; in_exp1 = 4'hC; in_mask1 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    n = 0;
    while (!res_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_latency", 32'(n), 32'd1);
    chk("t6_obs", 32'({res_obs1, res_pass1}), 32'({4'hC, 1'b1}));
    @(posedge clk);
    @(negedge clk);
    chk("t6_vec_cnt", 32'(vec_cnt1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
